// File: rtl/rv32i_pkg.sv
// Shared RV32I package: base instruction enums plus the writeback FSM state type
// and opcode classification helpers used by the writeback unit.
package rv32i_pkg;

    typedef enum logic [5:0] {
        LUI, AUIPC, JAL, JALR,
        BEQ, BNE, BLT, BGE, BLTU, BGEU,
        LB, LH, LW, LBU, LHU,
        SB, SH, SW,
        ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
        ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
        FENCE, ECALL, EBREAK
    } rv32i_base_instr;

    typedef enum logic [2:0] {
        R_TYPE, I_TYPE, S_TYPE, B_TYPE, U_TYPE, J_TYPE
    } rv32i_base_instr_type;

    typedef enum logic {
        IDLE,
        LOAD_WAIT
    } wb_state_t;

    function automatic logic is_load(input rv32i_base_instr op);
        return (op == LB) || (op == LH) || (op == LW) || (op == LBU) || (op == LHU);
    endfunction

    // Opcodes that architecturally produce a value for rd.
    function automatic logic writes_rd(input rv32i_base_instr op);
        case (op)
            LUI, AUIPC, JAL, JALR,
            LB, LH, LW, LBU, LHU,
            ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
            ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_data_align.sv
// Combinational load lane extraction: picks the byte/half lane from the aligned
// return word and sign- or zero-extends it to the register width.
module load_data_align
    import rv32i_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  rv32i_base_instr        opcode,
    input  logic [1:0]             offset,
    input  logic [DATA_WIDTH-1:0]  word,
    output logic [DATA_WIDTH-1:0]  data
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    assign lane_byte = word[{offset, 3'b000} +: 8];
    assign lane_half = offset[1] ? word[31:16] : word[15:0];

    always_comb begin
        data = word;
        case (opcode)
            LB:      data = {{(DATA_WIDTH-8){lane_byte[7]}}, lane_byte};
            LBU:     data = {{(DATA_WIDTH-8){1'b0}}, lane_byte};
            LH:      data = {{(DATA_WIDTH-16){lane_half[15]}}, lane_half};
            LHU:     data = {{(DATA_WIDTH-16){1'b0}}, lane_half};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: retires execute results into the register file, waiting on
// memory for loads. Define WB_BYPASS_EN to drive the fwd_* bypass from the write port.
module writeback_unit
    import rv32i_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    input  logic [ADDR_WIDTH-1:0]     pc_i,
    input  rv32i_base_instr           opcode_i,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr_i,
    input  logic [DATA_WIDTH-1:0]     alu_result_i,
    input  logic                      mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]     mem_rdata_i,
    output logic                      rf_we_o,
    output logic [REG_ADDR_WIDTH-1:0] rf_waddr_o,
    output logic [DATA_WIDTH-1:0]     rf_wdata_o,
    output logic                      retire_o,
    output logic                      misalign_o,
    output logic                      fwd_valid_o,
    output logic [REG_ADDR_WIDTH-1:0] fwd_addr_o,
    output logic [DATA_WIDTH-1:0]     fwd_data_o
);

    wb_state_t                 state;
    rv32i_base_instr           load_op;
    logic [REG_ADDR_WIDTH-1:0] load_rd;
    logic [1:0]                load_offset;
    logic [ADDR_WIDTH-1:0]     link_addr;
    logic [DATA_WIDTH-1:0]     load_data;
    logic                      misaligned;

    assign ready_o    = (state == IDLE) && !rst_i;
    assign link_addr  = pc_i + ADDR_WIDTH'(4);
    assign misaligned = (((opcode_i == LH) || (opcode_i == LHU)) && alu_result_i[0])
                      || ((opcode_i == LW) && (alu_result_i[1:0] != 2'b00));

    load_data_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_align (
        .opcode (load_op),
        .offset (load_offset),
        .word   (mem_rdata_i),
        .data   (load_data)
    );

    // Misaligned loads retire at once without touching memory or the register file.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            load_op     <= LUI;
            load_rd     <= '0;
            load_offset <= '0;
            rf_we_o     <= 1'b0;
            rf_waddr_o  <= '0;
            rf_wdata_o  <= '0;
            retire_o    <= 1'b0;
            misalign_o  <= 1'b0;
        end else begin
            rf_we_o    <= 1'b0;
            retire_o   <= 1'b0;
            misalign_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        if (is_load(opcode_i) && misaligned) begin
                            retire_o   <= 1'b1;
                            misalign_o <= 1'b1;
                        end else if (is_load(opcode_i)) begin
                            state       <= LOAD_WAIT;
                            load_op     <= opcode_i;
                            load_rd     <= rd_addr_i;
                            load_offset <= alu_result_i[1:0];
                        end else begin
                            retire_o   <= 1'b1;
                            rf_we_o    <= writes_rd(opcode_i) && (rd_addr_i != '0);
                            rf_waddr_o <= rd_addr_i;
                            if ((opcode_i == JAL) || (opcode_i == JALR))
                                rf_wdata_o <= DATA_WIDTH'(link_addr);
                            else
                                rf_wdata_o <= alu_result_i;
                        end
                    end
                end
                LOAD_WAIT: begin
                    if (mem_rvalid_i) begin
                        state      <= IDLE;
                        retire_o   <= 1'b1;
                        rf_we_o    <= (load_rd != '0);
                        rf_waddr_o <= load_rd;
                        rf_wdata_o <= load_data;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef WB_BYPASS_EN
    assign fwd_valid_o = rf_we_o;
    assign fwd_addr_o  = rf_waddr_o;
    assign fwd_data_o  = rf_wdata_o;
`else
    assign fwd_valid_o = 1'b0;
    assign fwd_addr_o  = '0;
    assign fwd_data_o  = '0;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Directed self-checking bench for writeback_unit: ALU, jump, load, misalign,
// reset-during-load and back-to-back retire sequences with hand-computed results.
module tb_writeback_unit;
    import rv32i_pkg::*;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic            valid_i = 1'b0;
    logic            ready_o;
    logic [31:0]     pc_i = '0;
    rv32i_base_instr opcode_i = ADDI;
    logic [4:0]      rd_addr_i = '0;
    logic [31:0]     alu_result_i = '0;
    logic            mem_rvalid_i = 1'b0;
    logic [31:0]     mem_rdata_i = '0;
    logic            rf_we_o;
    logic [4:0]      rf_waddr_o;
    logic [31:0]     rf_wdata_o;
    logic            retire_o;
    logic            misalign_o;
    logic            fwd_valid_o;
    logic [4:0]      fwd_addr_o;
    logic [31:0]     fwd_data_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    writeback_unit dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .pc_i         (pc_i),
        .opcode_i     (opcode_i),
        .rd_addr_i    (rd_addr_i),
        .alu_result_i (alu_result_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .rf_we_o      (rf_we_o),
        .rf_waddr_o   (rf_waddr_o),
        .rf_wdata_o   (rf_wdata_o),
        .retire_o     (retire_o),
        .misalign_o   (misalign_o),
        .fwd_valid_o  (fwd_valid_o),
        .fwd_addr_o   (fwd_addr_o),
        .fwd_data_o   (fwd_data_o)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
            $error("[TB] check %s", tag);
        end
    endtask

    // Presents one transfer for a single clock; outputs are sampled 1 time unit after the accepting edge.
    task automatic applyStimulus(input rv32i_base_instr op, input logic [31:0] pc,
                                 input logic [4:0] rd, input logic [31:0] alu);
        valid_i      = 1'b1;
        opcode_i     = op;
        pc_i         = pc;
        rd_addr_i    = rd;
        alu_result_i = alu;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic idleCycle();
        @(posedge clk_i);
        #1;
    endtask

    // Write-port plus bypass check; bypass mirrors the write port only when compiled in.
    task automatic checkWrite(input string tag, input logic we, input logic [4:0] addr,
                              input logic [31:0] data);
        checkOutput({tag, "_we"}, 32'(rf_we_o), 32'(we));
        if (we) begin
            checkOutput({tag, "_waddr"}, 32'(rf_waddr_o), 32'(addr));
            checkOutput({tag, "_wdata"}, rf_wdata_o, data);
        end
`ifdef WB_BYPASS_EN
        checkOutput({tag, "_fwd_valid"}, 32'(fwd_valid_o), 32'(we));
        if (we) begin
            checkOutput({tag, "_fwd_addr"}, 32'(fwd_addr_o), 32'(addr));
            checkOutput({tag, "_fwd_data"}, fwd_data_o, data);
        end
`else
        checkOutput({tag, "_fwd_valid"}, 32'(fwd_valid_o), 32'd0);
        checkOutput({tag, "_fwd_data"}, fwd_data_o, 32'd0);
`endif
    endtask

    // Issues a load, waits the given cycles with ready low, then returns data.
    task automatic runLoad(input string tag, input rv32i_base_instr op, input logic [31:0] addr,
                           input logic [4:0] rd, input logic [31:0] word, input int waits,
                           input logic [31:0] expected);
        applyStimulus(op, 32'h0000_0200, rd, addr);
        for (int i = 0; i < waits; i++) begin
            checkOutput({tag, "_ready_wait"}, 32'(ready_o), 32'd0);
            checkOutput({tag, "_retire_wait"}, 32'(retire_o), 32'd0);
            if (i < waits - 1) idleCycle();
        end
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = word;
        idleCycle();
        mem_rvalid_i = 1'b0;
        checkOutput({tag, "_retire"}, 32'(retire_o), 32'd1);
        checkOutput({tag, "_ready_after"}, 32'(ready_o), 32'd1);
        checkWrite(tag, 1'b1, rd, expected);
    endtask

    initial begin
        // Reset state
        idleCycle();
        idleCycle();
        checkOutput("rst_ready", 32'(ready_o), 32'd0);
        checkOutput("rst_we", 32'(rf_we_o), 32'd0);
        checkOutput("rst_retire", 32'(retire_o), 32'd0);
        checkOutput("rst_misalign", 32'(misalign_o), 32'd0);
        checkOutput("rst_waddr", 32'(rf_waddr_o), 32'd0);
        checkOutput("rst_wdata", rf_wdata_o, 32'd0);
        checkOutput("rst_fwd_valid", 32'(fwd_valid_o), 32'd0);
        checkOutput("rst_fwd_addr", 32'(fwd_addr_o), 32'd0);
        checkOutput("rst_fwd_data", fwd_data_o, 32'd0);
        rst_i = 1'b0;
        #1;
        checkOutput("post_rst_ready", 32'(ready_o), 32'd1);

        // ADDI rd=5 result 0x10
        applyStimulus(ADDI, 32'h0000_0040, 5'd5, 32'h0000_0010);
        checkWrite("addi", 1'b1, 5'd5, 32'h0000_0010);
        checkOutput("addi_retire", 32'(retire_o), 32'd1);
        checkOutput("addi_misalign", 32'(misalign_o), 32'd0);
        idleCycle();
        checkOutput("addi_we_pulse", 32'(rf_we_o), 32'd0);
        checkOutput("addi_retire_pulse", 32'(retire_o), 32'd0);

        // LB at 0x1003, data after 3 cycles: byte 0x80 sign-extended
        runLoad("lb", LB, 32'h0000_1003, 5'd7, 32'h80AB_CDEF, 3, 32'hFFFF_FF80);

        // Stray mem_rvalid_i while IDLE is ignored
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hDEAD_BEEF;
        idleCycle();
        mem_rvalid_i = 1'b0;
        checkOutput("idle_rvalid_we", 32'(rf_we_o), 32'd0);
        checkOutput("idle_rvalid_retire", 32'(retire_o), 32'd0);

        // Remaining lane/extension variants
        runLoad("lhu", LHU, 32'h0000_1002, 5'd8, 32'h80AB_CDEF, 1, 32'h0000_80AB);
        runLoad("lh", LH, 32'h0000_1000, 5'd9, 32'h80AB_CDEF, 2, 32'hFFFF_CDEF);
        runLoad("lbu", LBU, 32'h0000_1001, 5'd10, 32'h80AB_CDEF, 1, 32'h0000_00CD);
        runLoad("lw", LW, 32'h0000_1004, 5'd11, 32'h1234_5678, 1, 32'h1234_5678);

        // JAL link values, rd=0 suppression, and pc+4 wraparound
        applyStimulus(JAL, 32'h0000_0100, 5'd1, 32'h0000_0999);
        checkWrite("jal", 1'b1, 5'd1, 32'h0000_0104);
        checkOutput("jal_retire", 32'(retire_o), 32'd1);
        applyStimulus(JAL, 32'h0000_0100, 5'd0, 32'h0000_0999);
        checkWrite("jal_rd0", 1'b0, 5'd0, 32'd0);
        checkOutput("jal_rd0_retire", 32'(retire_o), 32'd1);
        applyStimulus(JALR, 32'hFFFF_FFFC, 5'd2, 32'h0000_0555);
        checkWrite("jalr_wrap", 1'b1, 5'd2, 32'h0000_0000);

        // Misaligned loads retire at once with no write
        applyStimulus(LW, 32'h0000_0300, 5'd3, 32'h0000_2002);
        checkOutput("lw_mis_misalign", 32'(misalign_o), 32'd1);
        checkOutput("lw_mis_retire", 32'(retire_o), 32'd1);
        checkOutput("lw_mis_we", 32'(rf_we_o), 32'd0);
        checkOutput("lw_mis_ready", 32'(ready_o), 32'd1);
        applyStimulus(LH, 32'h0000_0304, 5'd4, 32'h0000_2001);
        checkOutput("lh_mis_misalign", 32'(misalign_o), 32'd1);
        checkOutput("lh_mis_we", 32'(rf_we_o), 32'd0);
        checkOutput("lh_mis_ready", 32'(ready_o), 32'd1);

        // Branch with nonzero rd field: retires without writing
        applyStimulus(BEQ, 32'h0000_0308, 5'd3, 32'h0000_0001);
        checkWrite("beq", 1'b0, 5'd3, 32'd0);
        checkOutput("beq_retire", 32'(retire_o), 32'd1);
        checkOutput("beq_misalign", 32'(misalign_o), 32'd0);

        // Reset while waiting on a load, then a stale mem_rvalid_i
        applyStimulus(LW, 32'h0000_0400, 5'd9, 32'h0000_3000);
        checkOutput("ldrst_wait_ready", 32'(ready_o), 32'd0);
        rst_i = 1'b1;
        idleCycle();
        checkOutput("ldrst_ready_in_rst", 32'(ready_o), 32'd0);
        checkOutput("ldrst_we_in_rst", 32'(rf_we_o), 32'd0);
        rst_i        = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h1234_5678;
        #1;
        checkOutput("ldrst_ready_released", 32'(ready_o), 32'd1);
        idleCycle();
        mem_rvalid_i = 1'b0;
        checkOutput("ldrst_stale_we", 32'(rf_we_o), 32'd0);
        checkOutput("ldrst_stale_retire", 32'(retire_o), 32'd0);
        checkOutput("ldrst_ready", 32'(ready_o), 32'd1);

        // Back-to-back ADD, SUB, SW at one per cycle
        valid_i = 1'b1; opcode_i = ADD; rd_addr_i = 5'd10; alu_result_i = 32'h0000_0011;
        @(posedge clk_i); #1;
        checkWrite("b2b_add", 1'b1, 5'd10, 32'h0000_0011);
        opcode_i = SUB; rd_addr_i = 5'd11; alu_result_i = 32'h0000_0022;
        @(posedge clk_i); #1;
        checkWrite("b2b_sub", 1'b1, 5'd11, 32'h0000_0022);
        checkOutput("b2b_sub_retire", 32'(retire_o), 32'd1);
        opcode_i = SW; rd_addr_i = 5'd12; alu_result_i = 32'h0000_0033;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        checkWrite("b2b_sw", 1'b0, 5'd12, 32'd0);
        checkOutput("b2b_sw_retire", 32'(retire_o), 32'd1);
        checkOutput("b2b_ready", 32'(ready_o), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
